vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal and vertical sync, blanking, active-pixel coordinates and frame/line event pulses from a single system clock. It replaces the fixed 640x480 timing block feeding the pixel-colour logic in ChipInterface. Timing, pixel-clock division, sync polarity and a sync/blank alignment delay are set by parameters, so downstream colour logic with N cycles of lookup latency stays pixel-aligned.

## Interface
- CLK_DIV, 2: system clocks per pixel (>=1)
- H_DISP, 640: active pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_DISP, 480: active lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- HS_POL, 0: HS active level (0 = active-low)
- VS_POL, 0: VS active level
- PIPE, 0: extra clock delay applied to HS, VS, blank only (0..15)
- COL_W, 10 / ROW_W, 9: coordinate widths; require H_DISP <= 2**COL_W and V_DISP <= 2**ROW_W

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- HS  out  1  horizontal sync, level per HS_POL
- VS  out  1  vertical sync, level per VS_POL
- blank  out  1  high outside active region
- vblank  out  1  high on every non-active line, no PIPE delay
- row  out  ROW_W  active line index; 0 during blanking
- col  out  COL_W  active pixel index; 0 during blanking
- pix_en  out  1  one-clock pulse on the first clock of each pixel (every clock when CLK_DIV=1)
- line_start  out  1  one-clock pulse on first clock of pixel 0 of every line
- frame_start  out  1  one-clock pulse on first clock of pixel (0,0)
- frame_end  out  1  one-clock pulse on last clock of pixel (V_DISP-1, H_DISP-1)

## Operation
- Totals: H_TOT = H_DISP+H_FP+H_SYNC+H_BP pixels; V_TOT = V_DISP+V_FP+V_SYNC+V_BP lines.
- State: div (0..CLK_DIV-1), h (0..H_TOT-1), v (0..V_TOT-1). Widths are clog2 of each range.
- div increments every clock and wraps at CLK_DIV-1. h increments when div wraps. v increments when h and div both wrap. v wraps at V_TOT-1 to 0.
- Line order: active [0,H_DISP), front porch, sync [H_DISP+H_FP, H_DISP+H_FP+H_SYNC), back porch. The vertical order is the same in lines.
- HS is active while h is in the sync window. VS is active while v is in the sync window and changes only at line boundaries (h=0, div=0).
- Active region: h<H_DISP and v<V_DISP. In this region row=v and col=h; otherwise row=col=0 and blank=1.
- HS, VS and blank pass through a PIPE-stage shift register. All other outputs are not delayed.
- The block has no enable input and is free-running after reset.

## Timing
- All outputs are registered. Outputs in cycle t+1 decode the state held in cycle t. HS/VS/blank appear PIPE cycles later still.
- Reset, sampled at an edge, forces: div=h=v=0; HS=~HS_POL, VS=~VS_POL, blank=1, vblank=0, row=col=0, all pulses 0. Every PIPE stage loads inactive sync and blank=1.
- First edge with reset low: outputs reflect position (0,0,div0), giving frame_start=line_start=pix_en=1 and row=col=0. blank=0 appears at the same time when PIPE=0, or after PIPE further cycles otherwise.
- Reset asserted mid-frame takes effect at the next edge regardless of position, with no completion of the current line.
- Line period is CLK_DIV*H_TOT clocks. Frame period is CLK_DIV*H_TOT*V_TOT clocks. Every pulse fires exactly once per period.
- Wrap at (V_TOT-1, H_TOT-1, CLK_DIV-1): the next state is (0,0,0) with no gap cycle. frame_start follows frame_end after exactly CLK_DIV*((H_TOT-H_DISP) + H_TOT*(V_TOT-V_DISP)) + 1 clocks.

## Test plan
- Hold reset 5 clocks then release: during reset HS=VS=1, blank=1, pulses 0. On the first post-reset cycle, frame_start=line_start=pix_en=1, blank=0, row=col=0.
- Defaults, 2 frames: line_start period is 1600 clocks. HS is low for exactly 192 clocks, starting 1312 clocks after each line_start. pix_en fires every 2 clocks.
- Defaults: frame_start period is 840000 clocks. VS is low for 3200 clocks beginning at line 490. frame_end fires once per frame, with row=479 and col=639 in the same cycle.
- PIPE=3 vs PIPE=0, same stimulus: HS/VS/blank are shifted exactly 3 clocks later. row, col, vblank and all pulses are identical.
- CLK_DIV=1, H=4/1/2/1, V=3/1/1/1, HS_POL=VS_POL=1: every cycle of 3 frames matches the reference model. HS is high for 2 clocks per 8-clock line, and VS is high for 8 clocks per 48-clock frame.
- Assert reset for 1 clock at row 100, col 300: the next cycle shows reset values. The following cycle restarts at (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, blanking, active coordinates
// and line/frame event pulses from one system clock, with optional sync/blank delay.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned PIPE    = 0,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned ROW_W   = 9
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    output logic             HS,
    output logic             VS,
    output logic             blank,
    output logic             vblank,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             pix_en,
    output logic             line_start,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int unsigned H_TOT  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int unsigned V_W    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    localparam int unsigned HS_BEG = H_DISP + H_FP;
    localparam int unsigned HS_END = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG = V_DISP + V_FP;
    localparam int unsigned VS_END = VS_BEG + V_SYNC;

    logic [DIV_W-1:0] div;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;

    logic div_last, h_last, v_last;
    logic h_act_c, v_act_c, act_c, hs_c, vs_c;
    logic hs_r, vs_r, blank_r;

    // Position decode; compared at 32 bits so window ends may equal the totals.
    always_comb begin
        div_last = 1'b0;
        h_last   = 1'b0;
        v_last   = 1'b0;
        h_act_c  = 1'b0;
        v_act_c  = 1'b0;
        hs_c     = 1'b0;
        vs_c     = 1'b0;
        div_last = (32'(div) == CLK_DIV - 1);
        h_last   = (32'(h) == H_TOT - 1);
        v_last   = (32'(v) == V_TOT - 1);
        h_act_c  = (32'(h) < H_DISP);
        v_act_c  = (32'(v) < V_DISP);
        hs_c     = (32'(h) >= HS_BEG) && (32'(h) < HS_END);
        vs_c     = (32'(v) >= VS_BEG) && (32'(v) < VS_END);
    end

    assign act_c = h_act_c && v_act_c;

    // Raster counters: div -> h -> v, wrapping straight back to (0,0,0).
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= div_last ? '0 : div + DIV_W'(1);
            if (div_last) begin
                h <= h_last ? '0 : h + H_W'(1);
                if (h_last) begin
                    v <= v_last ? '0 : v + V_W'(1);
                end
            end
        end
    end

    // Registered decode of the current position.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hs_r        <= ~HS_POL;
            vs_r        <= ~VS_POL;
            blank_r     <= 1'b1;
            vblank      <= 1'b0;
            row         <= '0;
            col         <= '0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            hs_r        <= hs_c ? HS_POL : ~HS_POL;
            vs_r        <= vs_c ? VS_POL : ~VS_POL;
            blank_r     <= ~act_c;
            vblank      <= ~v_act_c;
            row         <= act_c ? ROW_W'(v) : '0;
            col         <= act_c ? COL_W'(h) : '0;
            pix_en      <= (div == '0);
            line_start  <= (div == '0) && (h == '0);
            frame_start <= (div == '0) && (h == '0) && (v == '0);
            frame_end   <= div_last && (32'(h) == H_DISP - 1) && (32'(v) == V_DISP - 1);
        end
    end

    // Alignment delay for HS/VS/blank so colour logic with lookup latency stays in step.
    if (PIPE == 0) begin : g_nopipe
        assign HS    = hs_r;
        assign VS    = vs_r;
        assign blank = blank_r;
    end else begin : g_pipe
        logic [PIPE-1:0] hs_d, vs_d, blank_d;

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                hs_d    <= {PIPE{~HS_POL}};
                vs_d    <= {PIPE{~VS_POL}};
                blank_d <= '1;
            end else begin
                hs_d    <= PIPE'({hs_d, hs_r});
                vs_d    <= PIPE'({vs_d, vs_r});
                blank_d <= PIPE'({blank_d, blank_r});
            end
        end

        assign HS    = hs_d[PIPE-1];
        assign VS    = vs_d[PIPE-1];
        assign blank = blank_d[PIPE-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three small raster configurations checked
// cycle by cycle against a position-from-cycle-count model plus measured periods.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs, vs, blank, vblank;
        logic [7:0] row, col;
        logic       pix_en, line_start, frame_start, frame_end;
    } obs_t;

    typedef struct {
        logic        rst;
        int unsigned k;
        obs_t        o;
    } item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_blank, a_vblank, a_pix, a_ls, a_fs, a_fe;
    logic [2:0] a_row;
    logic [3:0] a_col;
    logic       b_hs, b_vs, b_blank, b_vblank, b_pix, b_ls, b_fs, b_fe;
    logic [2:0] b_row;
    logic [3:0] b_col;
    logic       c_hs, c_vs, c_blank, c_vblank, c_pix, c_ls, c_fs, c_fe;
    logic [1:0] c_row;
    logic [1:0] c_col;

    // A: CLK_DIV=2, H 8/2/3/2 (15), V 4/1/2/1 (8), active-low syncs, no delay.
    vga_timing_gen #(.CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
                     .PIPE(0), .COL_W(4), .ROW_W(3)) dut_a (
        .CLOCK_50(clk), .reset(reset), .HS(a_hs), .VS(a_vs), .blank(a_blank), .vblank(a_vblank),
        .row(a_row), .col(a_col), .pix_en(a_pix), .line_start(a_ls), .frame_start(a_fs),
        .frame_end(a_fe));

    // B: same raster as A with a 3-clock sync/blank delay.
    vga_timing_gen #(.CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
                     .PIPE(3), .COL_W(4), .ROW_W(3)) dut_b (
        .CLOCK_50(clk), .reset(reset), .HS(b_hs), .VS(b_vs), .blank(b_blank), .vblank(b_vblank),
        .row(b_row), .col(b_col), .pix_en(b_pix), .line_start(b_ls), .frame_start(b_fs),
        .frame_end(b_fe));

    // C: CLK_DIV=1, H 4/1/2/1 (8), V 3/1/1/1 (6), active-high syncs.
    vga_timing_gen #(.CLK_DIV(1), .H_DISP(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_DISP(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
                     .PIPE(0), .COL_W(2), .ROW_W(2)) dut_c (
        .CLOCK_50(clk), .reset(reset), .HS(c_hs), .VS(c_vs), .blank(c_blank), .vblank(c_vblank),
        .row(c_row), .col(c_col), .pix_en(c_pix), .line_start(c_ls), .frame_start(c_fs),
        .frame_end(c_fe));

    item_t       qa[$], qb[$], qc[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned k = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Expected outputs k clocks after reset release (k=0: a reset cycle).
    function automatic obs_t model(input int unsigned cd, hd, hf, hsy, hb,
                                   input int unsigned vd, vf, vsy, vb,
                                   input bit hp, vp, input int unsigned pipe,
                                   input int unsigned kk);
        obs_t        o;
        int unsigned htot, vtot, p, q, dv, h, v, hq, vq;
        htot = hd + hf + hsy + hb;
        vtot = vd + vf + vsy + vb;
        o = '0;
        o.hs    = ~hp;
        o.vs    = ~vp;
        o.blank = 1'b1;
        if (kk == 0) return o;
        p  = kk - 1;
        dv = p % cd;
        h  = (p / cd) % htot;
        v  = (p / (cd * htot)) % vtot;
        o.vblank      = (v >= vd);
        o.row         = (h < hd && v < vd) ? 8'(v) : 8'd0;
        o.col         = (h < hd && v < vd) ? 8'(h) : 8'd0;
        o.pix_en      = (dv == 0);
        o.line_start  = (dv == 0) && (h == 0);
        o.frame_start = (dv == 0) && (h == 0) && (v == 0);
        o.frame_end   = (dv == cd - 1) && (h == hd - 1) && (v == vd - 1);
        if (p >= pipe) begin
            q  = p - pipe;
            hq = (q / cd) % htot;
            vq = (q / (cd * htot)) % vtot;
            o.hs    = (hq >= hd + hf && hq < hd + hf + hsy) ? hp : ~hp;
            o.vs    = (vq >= vd + vf && vq < vd + vf + vsy) ? vp : ~vp;
            o.blank = !(hq < hd && vq < vd);
        end
        return o;
    endfunction

    task automatic tick(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else k++;
        qa.push_back('{r, k, model(2, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 0, k)});
        qb.push_back('{r, k, model(2, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 3, k)});
        qc.push_back('{r, k, model(1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 0, k)});
    endtask

    int         t = 0;
    int         a_fs_cnt = 0;
    int         a_px_t = -1, a_ls_t = -1, a_fs_t = -1, a_fe_t = -1, a_hs_run = 0, a_vs_run = 0;
    int         c_ls_t = -1, c_fs_t = -1, c_fe_t = -1, c_hs_run = 0, c_vs_run = 0;
    logic [8:0] a_hist = '1;

    // Monitor: pops one expectation per DUT each clock and compares on the falling edge.
    always @(negedge clk) begin
        item_t ia, ib, ic;
        obs_t  oa, ob, oc;
        if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
            ia = qa.pop_front();
            ib = qb.pop_front();
            ic = qc.pop_front();
            t++;
            oa = {a_hs, a_vs, a_blank, a_vblank, 8'(a_row), 8'(a_col), a_pix, a_ls, a_fs, a_fe};
            ob = {b_hs, b_vs, b_blank, b_vblank, 8'(b_row), 8'(b_col), b_pix, b_ls, b_fs, b_fe};
            oc = {c_hs, c_vs, c_blank, c_vblank, 8'(c_row), 8'(c_col), c_pix, c_ls, c_fs, c_fe};
            check("a_cycle", 32'(oa), 32'(ia.o));
            check("b_cycle", 32'(ob), 32'(ib.o));
            check("c_cycle", 32'(oc), 32'(ic.o));
            if (ib.k > 3) begin
                check("b_sync_delay3", 32'({b_hs, b_vs, b_blank}), 32'(a_hist[8:6]));
                check("b_undelayed", 32'({b_vblank, b_row, b_col, b_pix, b_ls, b_fs, b_fe}),
                      32'({a_vblank, a_row, a_col, a_pix, a_ls, a_fs, a_fe}));
            end
            a_hist = {a_hist[5:0], a_hs, a_vs, a_blank};

            if (ia.rst) begin
                a_px_t = -1; a_ls_t = -1; a_fs_t = -1; a_fe_t = -1; a_hs_run = 0; a_vs_run = 0;
            end else begin
                if (a_pix) begin
                    if (a_px_t >= 0) check("a_pix_period", 32'(t - a_px_t), 32'd2);
                    a_px_t = t;
                end
                if (a_ls) begin
                    if (a_ls_t >= 0) check("a_line_period", 32'(t - a_ls_t), 32'd30);
                    a_ls_t = t;
                end
                if (a_fs) begin
                    a_fs_cnt++;
                    if (a_fs_t >= 0) check("a_frame_period", 32'(t - a_fs_t), 32'd240);
                    if (a_fe_t >= 0) check("a_end_to_start", 32'(t - a_fe_t), 32'd135);
                    a_fs_t = t;
                end
                if (a_fe) begin
                    check("a_end_pos", 32'({a_row, a_col}), 32'({3'd3, 4'd7}));
                    a_fe_t = t;
                end
                if (!a_hs) begin
                    if (a_hs_run == 0 && a_ls_t >= 0) check("a_hs_offset", 32'(t - a_ls_t), 32'd20);
                    a_hs_run++;
                end else if (a_hs_run > 0) begin
                    check("a_hs_width", 32'(a_hs_run), 32'd6);
                    a_hs_run = 0;
                end
                if (!a_vs) begin
                    if (a_vs_run == 0 && a_fs_t >= 0) check("a_vs_offset", 32'(t - a_fs_t), 32'd150);
                    a_vs_run++;
                end else if (a_vs_run > 0) begin
                    check("a_vs_width", 32'(a_vs_run), 32'd60);
                    a_vs_run = 0;
                end
            end

            if (ic.rst) begin
                c_ls_t = -1; c_fs_t = -1; c_fe_t = -1; c_hs_run = 0; c_vs_run = 0;
            end else begin
                check("c_pix_every_clock", 32'(c_pix), 32'd1);
                if (c_ls) begin
                    if (c_ls_t >= 0) check("c_line_period", 32'(t - c_ls_t), 32'd8);
                    c_ls_t = t;
                end
                if (c_fs) begin
                    if (c_fs_t >= 0) check("c_frame_period", 32'(t - c_fs_t), 32'd48);
                    if (c_fe_t >= 0) check("c_end_to_start", 32'(t - c_fe_t), 32'd29);
                    c_fs_t = t;
                end
                if (c_fe) begin
                    check("c_end_pos", 32'({c_row, c_col}), 32'({2'd2, 2'd3}));
                    c_fe_t = t;
                end
                if (c_hs) c_hs_run++;
                else if (c_hs_run > 0) begin
                    check("c_hs_width", 32'(c_hs_run), 32'd2);
                    c_hs_run = 0;
                end
                if (c_vs) c_vs_run++;
                else if (c_vs_run > 0) begin
                    check("c_vs_width", 32'(c_vs_run), 32'd8);
                    c_vs_run = 0;
                end
            end
        end
    end

    // Stimulus: reset, three A-frames, a one-clock reset at A row 2 col 5, then restart.
    initial begin
        repeat (5) tick(1'b1);
        repeat (720) tick(1'b0);
        while (k < 1031) tick(1'b0);
        tick(1'b1);
        repeat (500) tick(1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
        check("a_frame_start_count", 32'(a_fs_cnt), 32'd8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
